// File: rtl/psram_wb_arbiter_if.sv
// Wishbone classic bus bundle shared by the two master ports and the single
// PSRAM controller slave port of psram_wb_arbiter.
`timescale 1ns/1ps

interface psram_wb_arbiter_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;

  modport master (
    output adr, dat_w, sel, we, cyc, stb,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, cyc, stb,
    output dat_r, ack, err
  );
endinterface

// File: rtl/psram_wb_arbiter.sv
// Two-master Wishbone arbiter in front of the PSRAM quad controller: latched grant,
// idle gap between transfers, ack timeout. Define PSRAM_ARB_RR_EN for round-robin ties.
`timescale 1ns/1ps

module psram_wb_arbiter #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int GAP_CYC     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  psram_wb_arbiter_if.slave        m0,
  psram_wb_arbiter_if.slave        m1,
  psram_wb_arbiter_if.master       s,
  output logic [1:0]               grant_o,
  output logic                     busy_o
);

  // state | meaning
  // IDLE  | no transfer; arbitrate pending requests
  // XFER  | latched request on slave port, waiting for ack or timeout
  // GAP   | slave cyc/stb low so the controller FSM can return to idle
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);
  localparam logic [3:0]  GAP_LAST = 4'(GAP_CYC - 1);

  state_t      state;
  logic [15:0] to_cnt;
  logic [3:0]  gap_cnt;

  logic m0_req;
  logic m1_req;
  logic pick_m1;
  logic in_xfer;
  logic timeout_hit;
  logic done_ack;
  logic done_to;

  assign m0_req = m0.cyc & m0.stb;
  assign m1_req = m1.cyc & m1.stb;

`ifdef PSRAM_ARB_RR_EN
  logic prio_m1;

  assign pick_m1 = m1_req & (~m0_req | prio_m1);
`else
  assign pick_m1 = m1_req & ~m0_req;
`endif

  assign in_xfer     = (state == XFER);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
  assign done_ack    = in_xfer & s.ack;
  assign done_to     = in_xfer & ~s.ack & timeout_hit;

  // Ack/err are steered combinationally so the master sees the slave ack in its own cycle;
  // a master that dropped its request mid-transfer gets neither.
  assign m0.ack   = done_ack & grant_o[0] & m0_req;
  assign m1.ack   = done_ack & grant_o[1] & m1_req;
  assign m0.err   = done_to & grant_o[0] & m0_req;
  assign m1.err   = done_to & grant_o[1] & m1_req;
  assign m0.dat_r = grant_o[0] ? s.dat_r : 32'h0;
  assign m1.dat_r = grant_o[1] ? s.dat_r : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      to_cnt  <= 16'h0;
      gap_cnt <= 4'h0;
      grant_o <= 2'b00;
      busy_o  <= 1'b0;
      s.adr   <= 32'h0;
      s.dat_w <= 32'h0;
      s.sel   <= 4'h0;
      s.we    <= 1'b0;
      s.cyc   <= 1'b0;
      s.stb   <= 1'b0;
`ifdef PSRAM_ARB_RR_EN
      prio_m1 <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (m0_req | m1_req) begin
            s.adr   <= pick_m1 ? m1.adr   : m0.adr;
            s.dat_w <= pick_m1 ? m1.dat_w : m0.dat_w;
            s.sel   <= pick_m1 ? m1.sel   : m0.sel;
            s.we    <= pick_m1 ? m1.we    : m0.we;
            s.cyc   <= 1'b1;
            s.stb   <= 1'b1;
            grant_o <= pick_m1 ? 2'b10 : 2'b01;
            busy_o  <= 1'b1;
            to_cnt  <= 16'h0;
            state   <= XFER;
`ifdef PSRAM_ARB_RR_EN
            prio_m1 <= ~pick_m1;
`endif
          end
        end

        XFER: begin
          if (s.ack || timeout_hit) begin
            s.cyc   <= 1'b0;
            s.stb   <= 1'b0;
            grant_o <= 2'b00;
            gap_cnt <= GAP_LAST;
            state   <= GAP;
          end else begin
            to_cnt <= to_cnt + 16'h1;
          end
        end

        GAP: begin
          if (gap_cnt == 4'h0) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'h1;
          end
        end

        default: begin
          s.cyc   <= 1'b0;
          s.stb   <= 1'b0;
          grant_o <= 2'b00;
          busy_o  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Directed bench for psram_wb_arbiter: default-parameter instance plus a TIMEOUT_CYC=8 instance.
`timescale 1ns/1ps

module tb_psram_wb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  psram_wb_arbiter_if ifm0();
  psram_wb_arbiter_if ifm1();
  psram_wb_arbiter_if ifs();
  psram_wb_arbiter_if tm0();
  psram_wb_arbiter_if tm1();
  psram_wb_arbiter_if ts();

  logic [1:0] grant;
  logic       busy;
  logic [1:0] grant_t;
  logic       busy_t;

  psram_wb_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (ifm0),
    .m1      (ifm1),
    .s       (ifs),
    .grant_o (grant),
    .busy_o  (busy)
  );

  psram_wb_arbiter #(.TIMEOUT_CYC(8), .GAP_CYC(1)) dut_to (
    .clk     (clk),
    .rst_n   (rst_n),
    .m0      (tm0),
    .m1      (tm1),
    .s       (ts),
    .grant_o (grant_t),
    .busy_o  (busy_t)
  );

  logic [1:0] exp_g [4];

  task automatic init_signals();
    ifm0.adr = 0; ifm0.dat_w = 0; ifm0.sel = 0; ifm0.we = 0; ifm0.cyc = 0; ifm0.stb = 0;
    ifm1.adr = 0; ifm1.dat_w = 0; ifm1.sel = 0; ifm1.we = 0; ifm1.cyc = 0; ifm1.stb = 0;
    tm0.adr = 0;  tm0.dat_w = 0;  tm0.sel = 0;  tm0.we = 0;  tm0.cyc = 0;  tm0.stb = 0;
    tm1.adr = 0;  tm1.dat_w = 0;  tm1.sel = 0;  tm1.we = 0;  tm1.cyc = 0;  tm1.stb = 0;
    ifs.dat_r = 0; ifs.ack = 0; ifs.err = 0;
    ts.dat_r = 0;  ts.ack = 0;  ts.err = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifs.dat_r = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    checks++;
    if ({ifs.cyc, ifs.stb, ifs.we} !== 3'b000 || ifs.adr !== 32'h0 || ifs.dat_w !== 32'h0 || ifs.sel !== 4'h0) begin
      errors++; $display("FAIL reset_slave got cyc=%0b stb=%0b adr=%h want all 0", ifs.cyc, ifs.stb, ifs.adr);
    end
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_status got grant=%b busy=%b want 00 0", grant, busy);
    end
    checks++;
    if ({ifm0.ack, ifm0.err, ifm1.ack, ifm1.err} !== 4'b0 || ifm0.dat_r !== 32'h0 || ifm1.dat_r !== 32'h0) begin
      errors++; $display("FAIL reset_master got m0 dat=%h m1 dat=%h want 0", ifm0.dat_r, ifm1.dat_r);
    end
    ifs.dat_r = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    ifm0.adr = 32'h0000_0100; ifm0.we = 1'b0; ifm0.sel = 4'hF; ifm0.cyc = 1'b1; ifm0.stb = 1'b1;
    #1;
    checks++;
    if (ifs.stb !== 1'b0) begin
      errors++; $display("FAIL rd_early got stb=%0b want 0", ifs.stb);
    end
    @(negedge clk);
    checks++;
    if ({ifs.cyc, ifs.stb, ifs.we} !== 3'b110 || ifs.adr !== 32'h100 || grant !== 2'b01) begin
      errors++; $display("FAIL rd_start got cyc/stb/we=%b%b%b adr=%h grant=%b want 110 100 01",
                         ifs.cyc, ifs.stb, ifs.we, ifs.adr, grant);
    end
    repeat (20) @(negedge clk);
    ifs.ack = 1'b1; ifs.dat_r = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (ifm0.ack !== 1'b1 || ifm0.dat_r !== 32'hDEAD_BEEF || ifm0.err !== 1'b0) begin
      errors++; $display("FAIL rd_ack got ack=%0b dat=%h err=%0b want 1 deadbeef 0", ifm0.ack, ifm0.dat_r, ifm0.err);
    end
    checks++;
    if (ifm1.ack !== 1'b0 || ifm1.dat_r !== 32'h0) begin
      errors++; $display("FAIL rd_other got m1 ack=%0b dat=%h want 0 0", ifm1.ack, ifm1.dat_r);
    end
    @(negedge clk);
    ifs.ack = 1'b0; ifm0.cyc = 1'b0; ifm0.stb = 1'b0;
    checks++;
    if (ifs.cyc !== 1'b0 || busy !== 1'b1 || grant !== 2'b00) begin
      errors++; $display("FAIL rd_gap got cyc=%0b busy=%0b grant=%b want 0 1 00", ifs.cyc, busy, grant);
    end
    @(negedge clk);
    checks++;
    if (ifs.cyc !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rd_idle got cyc=%0b busy=%0b want 0 0", ifs.cyc, busy);
    end
    @(negedge clk);
  endtask

  task automatic test_write_hold();
    ifm1.adr = 32'h0000_0200; ifm1.dat_w = 32'h1234_5678; ifm1.sel = 4'b0011; ifm1.we = 1'b1;
    ifm1.cyc = 1'b1; ifm1.stb = 1'b1;
    @(negedge clk);
    checks++;
    if (ifs.adr !== 32'h200 || ifs.dat_w !== 32'h1234_5678 || ifs.sel !== 4'b0011 || ifs.we !== 1'b1 || grant !== 2'b10) begin
      errors++; $display("FAIL wr_start got adr=%h dat=%h sel=%b we=%0b grant=%b want 200 12345678 0011 1 10",
                         ifs.adr, ifs.dat_w, ifs.sel, ifs.we, grant);
    end
    ifm1.adr = 32'h0000_0300; ifm1.dat_w = 32'h0; ifm1.sel = 4'b1100; ifm1.we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ifs.adr !== 32'h200 || ifs.dat_w !== 32'h1234_5678 || ifs.sel !== 4'b0011 || ifs.we !== 1'b1 || ifs.stb !== 1'b1) begin
        errors++; $display("FAIL wr_hold cycle %0d got adr=%h dat=%h sel=%b we=%0b stb=%0b want 200 12345678 0011 1 1",
                           i, ifs.adr, ifs.dat_w, ifs.sel, ifs.we, ifs.stb);
      end
    end
    ifs.ack = 1'b1;
    #1;
    checks++;
    if (ifm1.ack !== 1'b1 || ifm0.ack !== 1'b0 || ifm1.err !== 1'b0) begin
      errors++; $display("FAIL wr_ack got m1 ack=%0b m0 ack=%0b err=%0b want 1 0 0", ifm1.ack, ifm0.ack, ifm1.err);
    end
    @(negedge clk);
    ifs.ack = 1'b0; ifm1.cyc = 1'b0; ifm1.stb = 1'b0; ifm1.we = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_tie();
    int n;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ifm0.adr = 32'hA0; ifm1.adr = 32'hB0;
    ifm0.cyc = 1'b1; ifm0.stb = 1'b1; ifm1.cyc = 1'b1; ifm1.stb = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (ifs.stb !== 1'b1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      checks++;
      if (grant !== exp_g[k] || ifs.stb !== 1'b1 || ifs.adr !== ((exp_g[k] == 2'b01) ? 32'hA0 : 32'hB0)) begin
        errors++; $display("FAIL tie_grant %0d got grant=%b stb=%0b adr=%h want grant=%b", k, grant, ifs.stb, ifs.adr, exp_g[k]);
      end
      if (k > 0) begin
        checks++;
        if (n !== 2) begin
          errors++; $display("FAIL tie_spacing %0d got %0d idle cycles want 2", k, n);
        end
      end
      ifs.ack = 1'b1;
      #1;
      checks++;
      if ({ifm1.ack, ifm0.ack} !== exp_g[k]) begin
        errors++; $display("FAIL tie_ack %0d got m1/m0 ack=%b%b want %b", k, ifm1.ack, ifm0.ack, exp_g[k]);
      end
      @(negedge clk);
      ifs.ack = 1'b0;
    end
    ifm0.cyc = 1'b0; ifm0.stb = 1'b0; ifm1.cyc = 1'b0; ifm1.stb = 1'b0;
    repeat (2) @(negedge clk);
    ifm0.cyc = 1'b1; ifm0.stb = 1'b1; ifm1.cyc = 1'b1; ifm1.stb = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || ifs.adr !== 32'hA0) begin
      errors++; $display("FAIL tie_first got grant=%b adr=%h want 01 a0", grant, ifs.adr);
    end
    ifs.ack = 1'b1;
    @(negedge clk);
    ifs.ack = 1'b0; ifm0.cyc = 1'b0; ifm0.stb = 1'b0;
    n = 0;
    while (ifs.stb !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (grant !== 2'b10 || ifs.stb !== 1'b1 || ifs.adr !== 32'hB0) begin
      errors++; $display("FAIL tie_second got grant=%b stb=%0b adr=%h want 10 1 b0", grant, ifs.stb, ifs.adr);
    end
    ifs.ack = 1'b1;
    @(negedge clk);
    ifs.ack = 1'b0; ifm1.cyc = 1'b0; ifm1.stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_abort_pending();
    int n;
    ifm0.adr = 32'h400; ifm0.cyc = 1'b1; ifm0.stb = 1'b1;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || ifs.adr !== 32'h400) begin
      errors++; $display("FAIL abort_start got grant=%b adr=%h want 01 400", grant, ifs.adr);
    end
    @(negedge clk);
    ifm1.adr = 32'h500; ifm1.we = 1'b0; ifm1.cyc = 1'b1; ifm1.stb = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ifm0.cyc = 1'b0; ifm0.stb = 1'b0;
    repeat (6) @(negedge clk);
    ifs.ack = 1'b1; ifs.dat_r = 32'h0BAD_0BAD;
    #1;
    checks++;
    if ({ifm0.ack, ifm0.err, ifm1.ack, ifm1.err} !== 4'b0000) begin
      errors++; $display("FAIL abort_ack got m0 ack/err=%b%b m1 ack/err=%b%b want 0000", ifm0.ack, ifm0.err, ifm1.ack, ifm1.err);
    end
    @(negedge clk);
    ifs.ack = 1'b0;
    checks++;
    if (grant !== 2'b00 || ifs.stb !== 1'b0) begin
      errors++; $display("FAIL abort_gap got grant=%b stb=%0b want 00 0", grant, ifs.stb);
    end
    n = 0;
    while (ifs.stb !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (grant !== 2'b10 || ifs.stb !== 1'b1 || ifs.adr !== 32'h500) begin
      errors++; $display("FAIL abort_pending got grant=%b stb=%0b adr=%h want 10 1 500", grant, ifs.stb, ifs.adr);
    end
    ifs.ack = 1'b1;
    #1;
    checks++;
    if (ifm1.ack !== 1'b1 || ifm1.dat_r !== 32'h0BAD_0BAD) begin
      errors++; $display("FAIL abort_m1_ack got ack=%0b dat=%h want 1 0bad0bad", ifm1.ack, ifm1.dat_r);
    end
    @(negedge clk);
    ifs.ack = 1'b0; ifm1.cyc = 1'b0; ifm1.stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int first = 0;
    int pulses = 0;
    int acks = 0;
    tm0.adr = 32'h600; tm0.cyc = 1'b1; tm0.stb = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk); #1;
      if (tm0.err === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
      if (tm0.ack !== 1'b0) acks++;
    end
    @(negedge clk); #1;
    if (tm0.err === 1'b1) pulses++;
    checks++;
    if (first !== 8 || pulses !== 1) begin
      errors++; $display("FAIL to_err_pulse got first cycle=%0d pulses=%0d want 8 1", first, pulses);
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL to_no_ack got %0d ack cycles want 0", acks);
    end
    checks++;
    if (busy_t !== 1'b1 || ts.cyc !== 1'b0 || grant_t !== 2'b00) begin
      errors++; $display("FAIL to_gap got busy=%0b cyc=%0b grant=%b want 1 0 00", busy_t, ts.cyc, grant_t);
    end
    tm0.cyc = 1'b0; tm0.stb = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_t !== 1'b0 || ts.stb !== 1'b0) begin
      errors++; $display("FAIL to_idle got busy=%0b stb=%0b want 0 0", busy_t, ts.stb);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_beats_timeout();
    tm0.adr = 32'h640; tm0.cyc = 1'b1; tm0.stb = 1'b1;
    repeat (8) @(negedge clk);
    ts.ack = 1'b1; ts.dat_r = 32'hCAFE_0001;
    #1;
    checks++;
    if (tm0.ack !== 1'b1 || tm0.err !== 1'b0 || tm0.dat_r !== 32'hCAFE_0001) begin
      errors++; $display("FAIL to_ack_wins got ack=%0b err=%0b dat=%h want 1 0 cafe0001", tm0.ack, tm0.err, tm0.dat_r);
    end
    @(negedge clk);
    ts.ack = 1'b0; tm0.cyc = 1'b0; tm0.stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ifm0.adr = 32'h700; ifm0.cyc = 1'b1; ifm0.stb = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b0; ifs.ack = 1'b1; ifs.dat_r = 32'h55;
    #1;
    checks++;
    if ({ifs.cyc, ifs.stb} !== 2'b00 || ifs.adr !== 32'h0 || grant !== 2'b00 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_mid_slave got cyc/stb=%b%b adr=%h grant=%b busy=%0b want 00 0 00 0",
                         ifs.cyc, ifs.stb, ifs.adr, grant, busy);
    end
    checks++;
    if (ifm0.ack !== 1'b0 || ifm0.err !== 1'b0 || ifm0.dat_r !== 32'h0) begin
      errors++; $display("FAIL rst_mid_master got ack=%0b err=%0b dat=%h want 0 0 0", ifm0.ack, ifm0.err, ifm0.dat_r);
    end
    @(negedge clk);
    rst_n = 1'b1; ifs.ack = 1'b0;
    @(negedge clk);
    checks++;
    if (grant !== 2'b01 || ifs.stb !== 1'b1 || ifs.adr !== 32'h700) begin
      errors++; $display("FAIL rst_mid_resume got grant=%b stb=%0b adr=%h want 01 1 700", grant, ifs.stb, ifs.adr);
    end
    ifs.ack = 1'b1; ifs.dat_r = 32'h77;
    #1;
    checks++;
    if (ifm0.ack !== 1'b1 || ifm0.dat_r !== 32'h77) begin
      errors++; $display("FAIL rst_mid_ack got ack=%0b dat=%h want 1 77", ifm0.ack, ifm0.dat_r);
    end
    @(negedge clk);
    ifs.ack = 1'b0; ifm0.cyc = 1'b0; ifm0.stb = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
`ifdef PSRAM_ARB_RR_EN
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
`else
    exp_g[0] = 2'b01; exp_g[1] = 2'b01; exp_g[2] = 2'b01; exp_g[3] = 2'b01;
`endif
    init_signals();
    test_reset();
    test_single_read();
    test_write_hold();
    test_tie();
    test_abort_pending();
    test_timeout();
    test_ack_beats_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
